// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and FSM state type for the FIFO byte packer
package fifo_pkg;
    localparam int DATA_WIDTH     = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int TIMEOUT        = 64;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_t;
endpackage

// File: rtl/packer_timeout.sv
// rtl/packer_timeout.sv - idle counter that flags when a partial word has waited TIMEOUT cycles
module packer_timeout #(
    parameter int TIMEOUT = fifo_pkg::TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic flush,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] count;

    // Saturates so a flush blocked by backpressure fires on the first free cycle
    always_ff @(posedge clk) begin
        if (rst || !idle || flush) begin
            count <= '0;
        end else if (count != TW'(TIMEOUT)) begin
            count <= count + TW'(1);
        end
    end

    assign expired = (count == TW'(TIMEOUT));
endmodule

// File: rtl/fifo_byte_packer.sv
// rtl/fifo_byte_packer.sv - packs FIFO bytes into little-endian words; PACKER_TIMEOUT_FLUSH_EN adds partial-word flush
module fifo_byte_packer #(
    parameter int DATA_WIDTH     = fifo_pkg::DATA_WIDTH,
    parameter int BYTES_PER_WORD = fifo_pkg::BYTES_PER_WORD,
    parameter int TIMEOUT        = fifo_pkg::TIMEOUT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 fifo_empty,
    output logic                                 fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]                fifo_dout,
    output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] out_data,
    output logic [BYTES_PER_WORD-1:0]            out_keep,
    output logic                                 out_valid,
    input  logic                                 out_ready
);
    import fifo_pkg::*;

    localparam int CW = $clog2(BYTES_PER_WORD + 1);
    localparam logic [CW:0] WORD_BYTES = (CW + 1)'(BYTES_PER_WORD);

    typedef logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0] word_t;

    if (BYTES_PER_WORD < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("fifo_byte_packer: BYTES_PER_WORD must be >= 2 and TIMEOUT >= 1");
    end

    packer_state_t                 state;
    logic [CW-1:0]                 cnt;
    logic                          pend;
    word_t                         asm_q;
    word_t                         land_word;
    word_t                         part_word;
    logic [BYTES_PER_WORD-1:0]     part_keep;
    logic [CW:0]                   fill_level;
    logic                          slot_free;
    logic                          last_lane;
    logic                          expired;
    logic                          flush;

    assign slot_free  = !out_valid || out_ready;
    assign fill_level = {1'b0, cnt} + (CW + 1)'(pend);
    assign last_lane  = (cnt == CW'(BYTES_PER_WORD - 1));

    // Look-ahead term keeps one byte per cycle across word boundaries
    assign fifo_rd_en = !rst && !fifo_empty && (state == FILL) &&
                        ((fill_level < WORD_BYTES) ||
                         ((fill_level == WORD_BYTES) && pend && slot_free));

    assign flush = expired && slot_free && (state == FILL) && !pend;

    always_comb begin
        land_word = asm_q;
        part_word = '0;
        part_keep = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (cnt == CW'(i)) begin
                land_word[i] = fifo_dout;
            end
            if (CW'(i) < cnt) begin
                part_word[i] = asm_q[i];
                part_keep[i] = 1'b1;
            end
        end
    end

`ifdef PACKER_TIMEOUT_FLUSH_EN
    logic idle;
    assign idle = (cnt != '0) && !pend && fifo_empty && (state == FILL);

    packer_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .idle   (idle),
        .flush  (flush),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            pend      <= 1'b0;
            asm_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
        end else begin
            pend <= fifo_rd_en;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                FILL: begin
                    if (pend) begin
                        asm_q <= land_word;
                        if (last_lane && slot_free) begin
                            out_data  <= land_word;
                            out_keep  <= '1;
                            out_valid <= 1'b1;
                            cnt       <= '0;
                        end else if (last_lane) begin
                            cnt   <= cnt + CW'(1);
                            state <= HOLD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (flush) begin
                        out_data  <= part_word;
                        out_keep  <= part_keep;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        out_data  <= asm_q;
                        out_keep  <= '1;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_byte_packer.sv
// tb/tb_fifo_byte_packer.sv - self-checking bench for fifo_byte_packer with a behavioural FIFO and byte-stream model
module tb_fifo_byte_packer;
    localparam int BPW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_dout = '0;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready = 1'b0;

    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = '0;
    logic [7:0]  fq[$];
    logic [7:0]  exp_q[$];
    int          fcount = 0;

    logic [31:0] words_q[$];
    logic [3:0]  keeps_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          valid_cycles = 0;
    int          rd_run = 0;
    int          rd_run_max = 0;
    int          last_rd_cyc = 0;
    int          rise_cyc = 0;
    logic        p_hold = 1'b0;
    logic        p_valid = 1'b0;
    logic [31:0] p_data = '0;
    logic [3:0]  p_keep = '0;

    always #5 clk = ~clk;

    fifo_byte_packer dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout (fifo_dout),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // 16-deep synchronous FIFO: registered dout, writes ignored when full
    assign fifo_empty = (fcount == 0);
    always @(posedge clk) begin
        int sz0;
        cyc++;
        if (rst) begin
            fq.delete();
            exp_q.delete();
            fifo_dout <= '0;
            fcount    <= 0;
        end else begin
            sz0 = fq.size();
            if (fifo_rd_en && sz0 > 0) fifo_dout <= fq.pop_front();
            if (wr_en && sz0 < 16) begin
                fq.push_back(wr_data);
                exp_q.push_back(wr_data);
            end
            fcount <= fq.size();
        end
    end

    always @(negedge clk) begin
        logic [31:0] ew;
        logic [3:0]  ek;
        int          n;
        if (rst) begin
            check("rd_en_in_reset", 64'(fifo_rd_en), 64'd0);
            rd_run = 0;
        end else begin
            if (fifo_rd_en) begin
                rd_run++;
                last_rd_cyc = cyc;
                if (rd_run > rd_run_max) rd_run_max = rd_run;
            end else begin
                rd_run = 0;
            end
            if (out_valid) valid_cycles++;
            if (out_valid && !p_valid) rise_cyc = cyc;
            if (p_hold) check("hold_stable", {27'd0, out_valid, out_keep, out_data}, {27'd0, 1'b1, p_keep, p_data});
            if (out_valid && out_ready) begin
`ifdef PACKER_TIMEOUT_FLUSH_EN
                n  = $countones(out_keep);
                ek = (n == 0) ? 4'hF : 4'((1 << n) - 1);
`else
                n  = BPW;
                ek = 4'hF;
`endif
                ew = '0;
                for (int i = 0; i < n; i++) begin
                    if (exp_q.size() == 0) check("byte_available", 64'd0, 64'd1);
                    else ew[i*8 +: 8] = exp_q.pop_front();
                end
                check("word", {28'd0, out_keep, out_data}, {28'd0, ek, ew});
                words_q.push_back(out_data);
                keeps_q.push_back(out_keep);
            end
        end
        p_hold  = !rst && out_valid && !out_ready;
        p_valid = !rst && out_valid;
        p_data  = out_data;
        p_keep  = out_keep;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic clear_log();
        words_q.delete();
        keeps_q.delete();
        valid_cycles = 0;
        rd_run_max   = 0;
    endtask

    initial begin
        // Reset values
        rst = 1'b1;
        step();
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
        check("reset_keep", 64'(out_keep), 64'd0);
        do_reset();

        // Single word, latency and one-cycle valid
        out_ready = 1'b1;
        clear_log();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        idle(10);
        check("t1_count", 64'(words_q.size()), 64'd1);
        if (words_q.size() > 0) begin
            check("t1_word", 64'(words_q[0]), 64'h44332211);
            check("t1_keep", 64'(keeps_q[0]), 64'hF);
        end
        check("t1_valid_cycles", 64'(valid_cycles), 64'd1);
        check("t1_latency", 64'(rise_cyc - last_rd_cyc), 64'd2);

        // Sustained throughput, word order
        clear_log();
        for (int i = 0; i < 16; i++) push(8'(i));
        idle(10);
        check("t2_rd_run", 64'(rd_run_max), 64'd16);
        check("t2_count", 64'(words_q.size()), 64'd4);
        if (words_q.size() == 4) begin
            check("t2_w0", 64'(words_q[0]), 64'h03020100);
            check("t2_w1", 64'(words_q[1]), 64'h07060504);
            check("t2_w2", 64'(words_q[2]), 64'h0B0A0908);
            check("t2_w3", 64'(words_q[3]), 64'h0F0E0D0C);
        end

        // Backpressure: one word presented, one held, rest stays in the FIFO
        clear_log();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        idle(5);
        check("t3_fifo_level", 64'(fcount), 64'd8);
        check("t3_valid", 64'(out_valid), 64'd1);
        check("t3_data", 64'(out_data), 64'h23222120);
        check("t3_rd_en", 64'(fifo_rd_en), 64'd0);
        check("t3_cnt", 64'(dut.cnt), 64'd4);
        check("t3_state_hold", 64'(dut.state), 64'd1);
        out_ready = 1'b1;
        idle(20);
        check("t3_count", 64'(words_q.size()), 64'd4);
        if (words_q.size() == 4) begin
            check("t3_w0", 64'(words_q[0]), 64'h23222120);
            check("t3_w1", 64'(words_q[1]), 64'h27262524);
            check("t3_w2", 64'(words_q[2]), 64'h2B2A2928);
            check("t3_w3", 64'(words_q[3]), 64'h2F2E2D2C);
        end

        // Lone byte: flushed after the timeout, or held forever
        do_reset();
        clear_log();
        push(8'hAB);
        idle(60);
        check("t4_no_early", 64'(words_q.size()), 64'd0);
`ifdef PACKER_TIMEOUT_FLUSH_EN
        idle(20);
        check("t4_count", 64'(words_q.size()), 64'd1);
        if (words_q.size() > 0) begin
            check("t4_word", 64'(words_q[0]), 64'h000000AB);
            check("t4_keep", 64'(keeps_q[0]), 64'h1);
        end
`else
        idle(100);
        check("t4_count", 64'(words_q.size()), 64'd0);
`endif

        // Reset mid-word discards the partial word
        do_reset();
        clear_log();
        push(8'h01); push(8'h02);
        idle(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        push(8'h05); push(8'h06); push(8'h07); push(8'h08);
        idle(10);
        check("t5_count", 64'(words_q.size()), 64'd1);
        if (words_q.size() > 0) check("t5_word", 64'(words_q[0]), 64'h08070605);

        // Random traffic against the byte-stream model
        do_reset();
        clear_log();
        for (int c = 0; c < 4000; c++) begin
            wr_en     = ($urandom_range(0, 3) != 0) && (fcount < 16);
            wr_data   = 8'($urandom);
            out_ready = (c % 500 < 60) ? 1'b0 : ($urandom_range(0, 2) != 0);
            step();
        end
        wr_en     = 1'b0;
        out_ready = 1'b1;
        idle(100);
        check("rand_words_seen", 64'(words_q.size() > 100), 64'd1);
`ifdef PACKER_TIMEOUT_FLUSH_EN
        check("rand_leftover", 64'(exp_q.size()), 64'd0);
`else
        check("rand_leftover", 64'(exp_q.size() < BPW), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
